// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the SPI/host command-RAM arbiter.
// Holds the RAM command opcodes and the arbiter FSM state encoding.
package spi_ram_arbiter_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_H_ADDR,
        ST_H_DATA,
        ST_H_WAIT
    } state_t;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Local host request/response port of the command-RAM arbiter.
// The host side drives the request; the arbiter answers with grant and read results.
interface spi_ram_arbiter_if #(parameter int ADDR_SIZE = 8);

    logic                 req;
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE-1:0] wdata;
    logic                 gnt;
    logic [ADDR_SIZE-1:0] rdata;
    logic                 rvalid;
    logic                 err;

    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid, err);
    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid, err);

endinterface

// File: rtl/spi_cmd_buffer.sv
// One-entry holding buffer for SPI command words with a registered drop flag.
// The head bypasses an incoming word so an idle arbiter can issue it the same cycle.
module spi_cmd_buffer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         drop
);

    logic         full_q;
    logic [W-1:0] data_q;
    logic         drop_q;

    assign head_valid = full_q | wr;
    assign head_data  = full_q ? data_q : wdata;
    assign drop       = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= wr & full_q & ~rd;
            if (full_q) begin
                // Draining the stored word makes room for a word arriving in the same cycle
                if (rd) begin
                    full_q <= wr;
                    if (wr) data_q <= wdata;
                end
            end else if (wr && !rd) begin
                full_q <= 1'b1;
                data_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the single-port command RAM between the SPI slave and a local host port.
// SPI always wins; an SPI address command locks the host out until its data command.
module spi_ram_arbiter
    import spi_ram_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE    = 8,
    parameter int RD_TIMEOUT   = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [ADDR_SIZE-1:0] spi_tx_data,
    output logic                 spi_tx_valid,
    spi_ram_arbiter_if.slave     host,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 spi_lock,
    output logic                 spi_drop
);

    localparam int RT_W = $clog2(RD_TIMEOUT + 1);
    localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [RT_W-1:0] RD_LAST   = RT_W'(RD_TIMEOUT - 1);
    localparam logic [LT_W-1:0] LOCK_LAST = LT_W'(LOCK_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
    logic [ADDR_SIZE+1:0]   din_q, din_d;
    logic                   rxv_q, rxv_d;
    logic                   gnt_q, gnt_d;
    logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic                   lock_q, lock_d;
    logic [LT_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic [RT_W-1:0]        rd_tmr_q, rd_tmr_d;
    logic                   head_valid, buf_rd, spi_issue;
    logic [ADDR_SIZE+1:0]   head_data;
    logic [1:0]             head_op;

    spi_cmd_buffer #(.W(ADDR_SIZE + 2)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (spi_rx_valid),
        .wdata      (spi_rx_data),
        .rd         (buf_rd),
        .head_valid (head_valid),
        .head_data  (head_data),
        .drop       (spi_drop)
    );

    assign head_op = head_data[ADDR_SIZE+1 -: 2];

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        din_d      = din_q;
        rxv_d      = 1'b0;
        gnt_d      = 1'b0;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        rd_tmr_d   = rd_tmr_q;
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        buf_rd     = 1'b0;
        spi_issue  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    buf_rd    = 1'b1;
                    spi_issue = 1'b1;
                    din_d     = head_data;
                    rxv_d     = 1'b1;
                end else if (host.req && !lock_q) begin
                    gnt_d   = 1'b1;
                    we_d    = host.we;
                    addr_d  = host.addr;
                    wdata_d = host.wdata;
                    state_d = ST_H_ADDR;
                end
            end
            ST_H_ADDR: begin
                din_d   = {(we_q ? CMD_WR_ADDR : CMD_RD_ADDR), addr_q};
                rxv_d   = 1'b1;
                state_d = ST_H_DATA;
            end
            ST_H_DATA: begin
                rxv_d = 1'b1;
                if (we_q) begin
                    din_d   = {CMD_WR_DATA, wdata_q};
                    state_d = ST_IDLE;
                end else begin
                    din_d    = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
                    rd_tmr_d = '0;
                    state_d  = ST_H_WAIT;
                end
            end
            ST_H_WAIT: begin
                if (ram_tx_valid) begin
                    rdata_d  = ram_dout;
                    rvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (rd_tmr_q == RD_LAST) begin
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    rd_tmr_d = rd_tmr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lock ages out on its own; a fresh SPI command overrides the ageing
        if (lock_q) begin
            if (lock_cnt_q == LOCK_LAST) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
        if (spi_issue) begin
            if (head_op == CMD_WR_ADDR || head_op == CMD_RD_ADDR) begin
                lock_d     = 1'b1;
                lock_cnt_d = '0;
            end else begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            din_q      <= '0;
            rxv_q      <= 1'b0;
            gnt_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_tmr_q   <= '0;
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            din_q      <= din_d;
            rxv_q      <= rxv_d;
            gnt_q      <= gnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rd_tmr_q   <= rd_tmr_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign ram_din      = din_q;
    assign ram_rx_valid = rxv_q;
    assign host.gnt     = gnt_q;
    assign host.rdata   = rdata_q;
    assign host.rvalid  = rvalid_q;
    assign host.err     = err_q;
    assign spi_lock     = lock_q;
    // Read data returning to the host must not be mistaken for an SPI read
    assign spi_tx_data  = ram_dout;
    assign spi_tx_valid = ram_tx_valid && (state_q != ST_H_WAIT);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_spi_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       spi_lock;
    logic       spi_drop;

    int errors = 0;
    int checks = 0;

    spi_ram_arbiter_if #(.ADDR_SIZE(8)) hif ();

    spi_ram_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(4), .LOCK_TIMEOUT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .host         (hif),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .spi_lock     (spi_lock),
        .spi_drop     (spi_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host read up to the cycle where the 11 command is on the RAM bus
    task automatic start_read(input logic [7:0] a);
        hif.req = 1'b1; hif.we = 1'b0; hif.addr = a; hif.wdata = 8'h00;
        tick();
        hif.req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_rx_data = '0; spi_rx_valid = 1'b0;
        ram_dout = '0; ram_tx_valid = 1'b0;
        hif.req = 1'b0; hif.we = 1'b0; hif.addr = '0; hif.wdata = '0;
        tick(); tick();
        checks++; if ({ram_rx_valid, ram_din} !== 11'h0) begin errors++; $display("FAIL reset_ram: got %h required 0", {ram_rx_valid, ram_din}); end
        checks++; if ({hif.gnt, hif.rvalid, hif.err, hif.rdata} !== 11'h0) begin errors++; $display("FAIL reset_host: got %h required 0", {hif.gnt, hif.rvalid, hif.err, hif.rdata}); end
        checks++; if ({spi_lock, spi_drop, spi_tx_valid, spi_tx_data} !== 11'h0) begin errors++; $display("FAIL reset_spi: got %h required 0", {spi_lock, spi_drop, spi_tx_valid, spi_tx_data}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_host_write();
        hif.req = 1'b1; hif.we = 1'b1; hif.addr = 8'h12; hif.wdata = 8'hA5;
        tick();
        checks++; if (hif.gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b required 1", hif.gnt); end
        hif.req = 1'b0;
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h012}) begin errors++; $display("FAIL wr_addr_cmd: got %b/%h required 1/012", ram_rx_valid, ram_din); end
        checks++; if (hif.gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_pulse: got %b required 0", hif.gnt); end
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h1A5}) begin errors++; $display("FAIL wr_data_cmd: got %b/%h required 1/1a5", ram_rx_valid, ram_din); end
        tick();
        checks++; if (ram_rx_valid !== 1'b0) begin errors++; $display("FAIL wr_end: got %b required 0", ram_rx_valid); end
    endtask

    task automatic test_host_read();
        hif.req = 1'b1; hif.we = 1'b0; hif.addr = 8'h12;
        tick();
        checks++; if (hif.gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b required 1", hif.gnt); end
        hif.req = 1'b0;
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h212}) begin errors++; $display("FAIL rd_addr_cmd: got %b/%h required 1/212", ram_rx_valid, ram_din); end
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h300}) begin errors++; $display("FAIL rd_data_cmd: got %b/%h required 1/300", ram_rx_valid, ram_din); end
        tick(); tick();
        ram_tx_valid = 1'b1; ram_dout = 8'hA5;
        #1;
        checks++; if (spi_tx_valid !== 1'b0) begin errors++; $display("FAIL rd_spi_suppress: got %b required 0", spi_tx_valid); end
        tick();
        ram_tx_valid = 1'b0; ram_dout = 8'h00;
        checks++; if ({hif.rvalid, hif.err, hif.rdata} !== {1'b1, 1'b0, 8'hA5}) begin errors++; $display("FAIL rd_result: got %b/%b/%h required 1/0/a5", hif.rvalid, hif.err, hif.rdata); end
        tick();
        checks++; if (hif.rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b required 0", hif.rvalid); end
    endtask

    task automatic test_read_timeout();
        start_read(8'h33);
        tick(); tick(); tick();
        checks++; if (hif.rvalid !== 1'b0) begin errors++; $display("FAIL to_early: got %b required 0", hif.rvalid); end
        tick();
        checks++; if ({hif.rvalid, hif.err, hif.rdata} !== {1'b1, 1'b1, 8'h00}) begin errors++; $display("FAIL to_result: got %b/%b/%h required 1/1/00", hif.rvalid, hif.err, hif.rdata); end
        tick();
        checks++; if ({hif.rvalid, hif.err} !== 2'b00) begin errors++; $display("FAIL to_pulse: got %b required 00", {hif.rvalid, hif.err}); end
    endtask

    task automatic test_simultaneous();
        spi_rx_data = 10'h1C3; spi_rx_valid = 1'b1;
        hif.req = 1'b1; hif.we = 1'b1; hif.addr = 8'h55; hif.wdata = 8'h66;
        tick();
        spi_rx_valid = 1'b0;
        checks++; if ({ram_rx_valid, ram_din, hif.gnt} !== {1'b1, 10'h1C3, 1'b0}) begin errors++; $display("FAIL sim_spi_first: got %b/%h/%b required 1/1c3/0", ram_rx_valid, ram_din, hif.gnt); end
        tick();
        checks++; if ({hif.gnt, ram_rx_valid} !== 2'b10) begin errors++; $display("FAIL sim_host_gnt: got %b required 10", {hif.gnt, ram_rx_valid}); end
        hif.req = 1'b0;
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h055}) begin errors++; $display("FAIL sim_host_addr: got %b/%h required 1/055", ram_rx_valid, ram_din); end
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h166}) begin errors++; $display("FAIL sim_host_data: got %b/%h required 1/166", ram_rx_valid, ram_din); end
        tick();
    endtask

    task automatic test_lock_release();
        spi_rx_data = 10'h2AA; spi_rx_valid = 1'b1;
        tick();
        checks++; if ({spi_lock, ram_din} !== {1'b1, 10'h2AA}) begin errors++; $display("FAIL lr_set: got %b/%h required 1/2aa", spi_lock, ram_din); end
        spi_rx_data = 10'h300;
        tick();
        spi_rx_valid = 1'b0;
        checks++; if ({spi_lock, ram_rx_valid, ram_din} !== {1'b0, 1'b1, 10'h300}) begin errors++; $display("FAIL lr_clear: got %b/%b/%h required 0/1/300", spi_lock, ram_rx_valid, ram_din); end
        tick();
    endtask

    task automatic test_lock_timeout();
        int lock_cycles = 0;
        int gnt_seen = 0;
        int guard = 0;
        spi_rx_data = 10'h034; spi_rx_valid = 1'b1;
        hif.req = 1'b1; hif.we = 1'b1; hif.addr = 8'h77; hif.wdata = 8'h88;
        tick();
        spi_rx_valid = 1'b0;
        checks++; if ({spi_lock, ram_rx_valid, ram_din} !== {1'b1, 1'b1, 10'h034}) begin errors++; $display("FAIL lt_set: got %b/%b/%h required 1/1/034", spi_lock, ram_rx_valid, ram_din); end
        while (spi_lock === 1'b1 && guard < 200) begin
            if (hif.gnt === 1'b1) gnt_seen++;
            lock_cycles++;
            guard++;
            tick();
        end
        checks++; if (lock_cycles !== 64) begin errors++; $display("FAIL lt_duration: got %0d cycles required 64", lock_cycles); end
        checks++; if (gnt_seen !== 0) begin errors++; $display("FAIL lt_no_gnt: got %0d grants required 0", gnt_seen); end
        tick();
        checks++; if (hif.gnt !== 1'b1) begin errors++; $display("FAIL lt_gnt_after: got %b required 1", hif.gnt); end
        hif.req = 1'b0;
        tick();
        checks++; if (ram_din !== 10'h077) begin errors++; $display("FAIL lt_host_addr: got %h required 077", ram_din); end
        tick(); tick();
    endtask

    task automatic test_drop_during_wait();
        start_read(8'h40);
        spi_rx_data = 10'h1FF; spi_rx_valid = 1'b1;
        tick();
        spi_rx_data = 10'h0AB;
        tick();
        spi_rx_valid = 1'b0;
        checks++; if (spi_drop !== 1'b1) begin errors++; $display("FAIL dr_drop: got %b required 1", spi_drop); end
        tick();
        checks++; if (spi_drop !== 1'b0) begin errors++; $display("FAIL dr_drop_pulse: got %b required 0", spi_drop); end
        tick();
        checks++; if ({hif.rvalid, hif.err, ram_rx_valid} !== 3'b110) begin errors++; $display("FAIL dr_wait_end: got %b required 110", {hif.rvalid, hif.err, ram_rx_valid}); end
        tick();
        checks++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h1FF}) begin errors++; $display("FAIL dr_issue: got %b/%h required 1/1ff", ram_rx_valid, ram_din); end
        tick();
        checks++; if (ram_rx_valid !== 1'b0) begin errors++; $display("FAIL dr_second_gone: got %b required 0", ram_rx_valid); end
    endtask

    task automatic test_reset_mid();
        int rv_seen = 0;
        start_read(8'h21);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({ram_rx_valid, ram_din, hif.gnt, hif.rvalid, hif.err, hif.rdata, spi_lock, spi_drop} !== 24'h0) begin errors++; $display("FAIL rm_outputs: got %h required 0", {ram_rx_valid, ram_din, hif.gnt, hif.rvalid, hif.err, hif.rdata, spi_lock, spi_drop}); end
        tick(); tick();
        rst_n = 1'b1;
        ram_tx_valid = 1'b1; ram_dout = 8'h5A;
        #1;
        checks++; if ({spi_tx_valid, spi_tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rm_spi_tx: got %b/%h required 1/5a", spi_tx_valid, spi_tx_data); end
        for (int i = 0; i < 6; i++) begin
            tick();
            ram_tx_valid = 1'b0; ram_dout = 8'h00;
            if (hif.rvalid === 1'b1) rv_seen++;
        end
        checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rm_no_rvalid: got %0d pulses required 0", rv_seen); end
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_host_read();
        test_read_timeout();
        test_simultaneous();
        test_lock_release();
        test_lock_timeout();
        test_drop_during_wait();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port command RAM between the SPI slave and a local host port.
- Sits between the SPI slave (rx_data/rx_valid in, tx_data/tx_valid out) and the RAM (Din/rx_valid in, Dout/tx_valid out).
- Keeps the RAM 2-bit command protocol intact for both requesters: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- Locks out the host between an SPI address command and its data command, so the RAM's latched address is never clobbered.

Parameters:
- ADDR_SIZE, 8, RAM address / data byte width (command word = ADDR_SIZE+2).
- RD_TIMEOUT, 4, cycles to wait for ram_tx_valid after issuing a host 11 command.
- LOCK_TIMEOUT, 64, cycles an SPI address lock may persist without its data command.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- spi_rx_data  in  10  command word from SPI slave
- spi_rx_valid  in  1  one-cycle strobe for spi_rx_data
- spi_tx_data  out  8  read byte to SPI slave (ram_dout pass-through)
- spi_tx_valid  out  1  read strobe to SPI slave
- host_req  in  1  host request, held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  8  host address
- host_wdata  in  8  host write data
- host_gnt  out  1  one-cycle pulse: host request accepted
- host_rdata  out  8  host read data
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- host_err  out  1  one-cycle pulse: read timed out (host_rdata = 0)
- ram_din  out  10  command word to RAM (registered)
- ram_rx_valid  out  1  command strobe to RAM (registered)
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read strobe
- spi_lock  out  1  SPI address lock active
- spi_drop  out  1  one-cycle pulse: SPI command lost, buffer full

Behaviour:
- Reset: all outputs 0. State IDLE, pending buffer empty, lock clear, counters 0.
- Pending buffer:
  - One-entry buffer for SPI commands. Every spi_rx_valid writes it.
  - If the buffer is full and not being drained the same cycle, the new word is dropped and spi_drop pulses.
- States: IDLE, H_ADDR, H_DATA, H_WAIT.
- IDLE priority:
  - (1) Pending SPI command: drive ram_din = word, ram_rx_valid = 1 next cycle; buffer drains. Latency spi_rx_valid -> ram_rx_valid = 1 cycle when idle.
  - (2) Otherwise, if host_req and !spi_lock: host_gnt pulses, capture we/addr/wdata, go to H_ADDR.
- H_ADDR: issue {we?00:10, addr}, go to H_DATA.
- H_DATA:
  - Write: issue {01, wdata}, go to IDLE.
  - Read: issue {11, 8'h00}, go to H_WAIT, clear timer.
- H_WAIT:
  - ram_tx_valid: host_rdata = ram_dout, host_rvalid pulse, go to IDLE.
  - Timer reaches RD_TIMEOUT: host_rdata = 0, host_rvalid and host_err pulse, go to IDLE.
- SPI commands arriving in H_ADDR/H_DATA/H_WAIT are buffered and issued in the first IDLE cycle after.
- Lock:
  - Set when an SPI 00 or 10 command is issued to the RAM.
  - Cleared when an SPI 01 or 11 is issued, or when the lock counter reaches LOCK_TIMEOUT.
  - The counter restarts on each SPI addr command. While the lock is set the host is never granted.
- spi_tx routing: spi_tx_data = ram_dout always. spi_tx_valid = ram_tx_valid when state != H_WAIT; suppressed in H_WAIT.
- Simultaneous SPI command and host_req in IDLE with empty buffer: the SPI word enters the buffer that cycle. The host is granted only when the buffer is empty and no spi_rx_valid is present (SPI wins ties).
- Lock timeout: releases without a status pulse other than spi_lock falling.
- Reset mid-operation: sequence abandoned, no host_rvalid, buffer and lock cleared.

Decomposition:
- Shared package: command opcode constants CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11; state enum.
- One natural sub-module: spi_cmd_buffer (one-entry buffer with drop flag).
- FSM, lock counter and read timer stay in the top module.

Test Plan:
- Host write addr 8'h12, data 8'hA5, SPI idle -> host_gnt 1 cycle later; ram_din 10'h012 then 10'h1A5 on consecutive cycles.
- Host read addr 8'h12, RAM returns tx_valid with 8'hA5 two cycles after the 11 command -> host_rvalid with host_rdata 8'hA5; spi_tx_valid stays 0.
- SPI sends 10'h034; host_req held; SPI never sends data -> spi_lock = 1; no host_gnt for 64 cycles; lock drops; host then granted.
- spi_rx_valid and host_req in the same cycle -> SPI word on ram_din next cycle; host_gnt one cycle later.
- SPI word 10'h1FF arrives during H_WAIT, then a second SPI word before IDLE -> first issued in the first IDLE cycle; second dropped with spi_drop pulse.
- Host read with no ram_tx_valid -> host_rvalid and host_err pulse after 4 H_WAIT cycles, host_rdata = 0.
- rst_n low during H_WAIT -> all outputs 0; no host_rvalid.
